// File: rtl/simon_sequencer_if.sv
// Simon game bundle: player/start inputs toward the engine, playback and
// game status back toward the LED/display side.
interface simon_sequencer_if #(
    parameter int COLOR_W = 2,
    parameter int MAX_LEN = 16
);
    localparam int RW = $clog2(MAX_LEN + 1);

    logic               start;
    logic               player_pressed;
    logic [COLOR_W-1:0] player_num;
    logic               simon_turn;
    logic               simon_pressed;
    logic [COLOR_W-1:0] simon_num;
    logic               player_turn;
    logic [RW-1:0]      round_len;
    logic               game_over;
    logic               game_won;

    modport master (
        output start,
        output player_pressed,
        output player_num,
        input  simon_turn,
        input  simon_pressed,
        input  simon_num,
        input  player_turn,
        input  round_len,
        input  game_over,
        input  game_won
    );

    modport slave (
        input  start,
        input  player_pressed,
        input  player_num,
        output simon_turn,
        output simon_pressed,
        output simon_num,
        output player_turn,
        output round_len,
        output game_over,
        output game_won
    );
endinterface

// File: rtl/simon_sequencer.sv
// Simon game engine: grows an LFSR-driven colour sequence one element per
// round, plays it back with timed pulses and checks the player's replay.
module simon_sequencer #(
    parameter int          COLOR_W        = 2,
    parameter int          MAX_LEN        = 16,
    parameter int          SHOW_CYCLES    = 4,
    parameter int          GAP_CYCLES     = 2,
    parameter int          TIMEOUT_CYCLES = 0,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input logic clk,
    input logic rst_n,
    simon_sequencer_if.slave bus
);
    localparam int RW     = $clog2(MAX_LEN + 1);
    localparam int IW     = $clog2(MAX_LEN);
    localparam int TMAX_A = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TMAX   = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);
    localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
    localparam int TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [15:0] POLY = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHOW,
        GAP,
        WAIT,
        LOSE,
        WIN
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [15:0]        lfsr;
    logic [RW-1:0]      len;
    logic [RW-1:0]      len_n;
    logic [IW-1:0]      show_idx;
    logic [IW-1:0]      show_idx_n;
    logic [IW-1:0]      play_idx;
    logic [IW-1:0]      play_idx_n;
    logic [IW-1:0]      last_idx;
    logic [TW-1:0]      timer;
    logic [TW-1:0]      timer_n;
    logic [COLOR_W-1:0] mem [MAX_LEN];
    logic               hit;
    logic               show_done;
    logic               gap_done;
    logic               timed_out;

    assign last_idx  = IW'(len - RW'(1));
    assign hit       = (bus.player_num == mem[play_idx]);
    assign show_done = (timer == TW'(SHOW_CYCLES - 1));
    assign gap_done  = (timer == TW'(GAP_CYCLES - 1));
    assign timed_out = TO_EN && (timer == TW'(TO_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len      <= '0;
            show_idx <= '0;
            play_idx <= '0;
            timer    <= '0;
        end else begin
            state    <= state_n;
            len      <= len_n;
            show_idx <= show_idx_n;
            play_idx <= play_idx_n;
            timer    <= timer_n;
        end
    end

    // Contents need no reset: every slot is written in ADD before it is read.
    always_ff @(posedge clk) begin
        if (state == ADD) begin
            mem[last_idx] <= lfsr[COLOR_W-1:0];
        end
    end

    always_comb begin
        state_n    = state;
        len_n      = len;
        show_idx_n = show_idx;
        play_idx_n = play_idx;
        timer_n    = timer;
        unique case (state)
            IDLE, LOSE, WIN: begin
                if (bus.start) begin
                    len_n   = RW'(1);
                    state_n = ADD;
                end
            end
            ADD: begin
                show_idx_n = '0;
                timer_n    = '0;
                state_n    = SHOW;
            end
            SHOW: begin
                if (show_done) begin
                    timer_n = '0;
                    state_n = GAP;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            GAP: begin
                if (gap_done) begin
                    timer_n = '0;
                    if (show_idx == last_idx) begin
                        play_idx_n = '0;
                        state_n    = WAIT;
                    end else begin
                        show_idx_n = show_idx + IW'(1);
                        state_n    = SHOW;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            WAIT: begin
                // A press on the last timeout cycle still counts.
                if (bus.player_pressed) begin
                    if (!hit) begin
                        state_n = LOSE;
                    end else if (play_idx == last_idx) begin
                        if (len == RW'(MAX_LEN)) begin
                            state_n = WIN;
                        end else begin
                            len_n   = len + RW'(1);
                            state_n = ADD;
                        end
                    end else begin
                        play_idx_n = play_idx + IW'(1);
                        timer_n    = '0;
                    end
                end else if (timed_out) begin
                    state_n = LOSE;
                end else if (TO_EN) begin
                    timer_n = timer + TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.simon_turn    = (state == ADD) || (state == SHOW) || (state == GAP);
    assign bus.simon_pressed = (state == SHOW);
    assign bus.simon_num     = (state == SHOW) ? mem[show_idx] : '0;
    assign bus.player_turn   = (state == WAIT);
    assign bus.round_len     = len;
    assign bus.game_over     = (state == LOSE);
    assign bus.game_won      = (state == WIN);

endmodule
